mmio_decoder: RTL and testbench
===============================

// Module: mmio_decoder
// PURPOSE
//   Parametrised CPU-side address decoder and memory-mapped I/O block between the cpu and the ram/peripherals.
//   Splits the CPU address space into a RAM window and an I/O window.
//   Sequences multi-cycle RAM accesses with a req/ack handshake.
//   Hosts NUM_PORTS output port registers (LED/display class) with write/set/clear/toggle operations.
// PARAMETERS
//   AW          12   CPU address width; addr[AW-1]=0 -> RAM window, 1 -> I/O window
//   DW          8    data width
//   NUM_PORTS   4    number of output port registers (1..16)
//   RAM_LAT     1    RAM read latency in cycles, 1..7 (ram_rdata valid RAM_LAT cycles after ram_cs)
//   PORT_RST    '0   reset value of every port register (DW bits)
// PORTS
//   clk        in   1              single clock, all logic on posedge
//   reset      in   1              synchronous, active-high
//   cpu_req    in   1              transaction request, held with addr/rw/wdata stable until ack
//   cpu_rw     in   1              1=read, 0=write
//   cpu_addr   in   AW             byte address
//   cpu_wdata  in   DW             write data
//   cpu_rdata  out  DW             read data, valid while cpu_ack=1
//   cpu_ack    out  1              one-cycle completion pulse
//   cpu_err    out  1              with ack: access to unmapped port index
//   ram_cs     out  1              one-cycle RAM select
//   ram_rw     out  1              copy of cpu_rw
//   ram_addr   out  AW-1           cpu_addr[AW-2:0]
//   ram_wdata  out  DW             copy of cpu_wdata
//   ram_rdata  in   DW             RAM read data
//   port_out   out  NUM_PORTS*DW   port registers, port i at [i*DW +: DW]
//   port_stb   out  NUM_PORTS      one-cycle pulse when port i is updated
// BEHAVIOUR
//   Reset: state IDLE; cpu_ack, cpu_err, ram_cs, port_stb = 0; cpu_rdata = 0; every port = PORT_RST.
//   I/O decode: idx = cpu_addr[5:2], op = cpu_addr[1:0]: 00 WRITE, 01 SET (|=), 10 CLEAR (&=~), 11 TOGGLE (^=).
//     Reads return port[idx] for any op. idx >= NUM_PORTS: write ignored, read returns 0, cpu_err=1 with ack.
//     cpu_addr[AW-2:6] are don't-care (ports alias).
//   FSM states IDLE, RAM_WAIT, DONE; req sampled only in IDLE.
//     IDLE, req, RAM window (issue cycle T): ram_cs=1 (combinational) -> RAM_WAIT, cnt=RAM_LAT-1.
//     IDLE, req, I/O window (cycle T): port op applied at end of T; port_stb[idx]=1 during T+1;
//       rdata = pre-update port value -> DONE.
//     RAM_WAIT: cnt==0 -> capture ram_rdata into cpu_rdata -> DONE; else cnt--.
//     DONE: cpu_ack=1 for exactly this cycle -> IDLE unconditionally.
//   Latency, issue at T: I/O ack at T+1; RAM ack at T+RAM_LAT+1.
//     RAM writes use the same timing; cpu_rdata=0 on writes.
//   Requester drops req in the ack cycle; req still high in the following IDLE cycle starts a new transaction.
//   Minimum spacing between issues: 2 cycles (I/O), RAM_LAT+2 cycles (RAM).
//   ram_cs is never asserted outside IDLE, so no second RAM access is issued while one is in flight.
//   cpu_rdata holds its last value when cpu_ack=0.
//   Reset mid-transaction: FSM -> IDLE, no ack is produced, ports -> PORT_RST; the aborted access is lost.
//   Port op widths: all DW bits, no carry; TOGGLE with wdata=0 still pulses port_stb.
// STRUCTURE
//   mmio_pkg: typedef enum logic [1:0] {IDLE, RAM_WAIT, DONE} mmio_state_t; localparams OP_WRITE/OP_SET/OP_CLEAR/OP_TOGGLE.
//   Sub-module mmio_port_reg (params DW, PORT_RST): one register with we/op/wdata -> q, stb.
//     Instantiated NUM_PORTS times in a generate loop.
//   Top level holds the decode, the FSM, the RAM latency counter and the read mux.
// TESTING
//   1. Reset held 3 cycles with req=1 -> ack=0, ram_cs=0, all ports=PORT_RST, rdata=0.
//   2. Write 0xA5 to port 1 (addr 0x804), then read 0x804 -> ack at T+1 each; read data 0xA5; port_stb=0b0010 once.
//   3. Port 1=0xA5: SET 0x0F (0x805) -> 0xAF; CLEAR 0xA0 (0x806) -> 0x0F; TOGGLE 0xFF (0x807) -> 0xF0.
//   4. RAM_LAT=3: write 0x3C to 0x010, read 0x010 -> ram_cs exactly 1 cycle each; read ack at T+4, rdata 0x3C.
//   5. NUM_PORTS=4: write to idx 5 (0x814) -> ack with cpu_err=1, no port change, no stb; read returns 0.
//   6. Reset asserted during RAM_WAIT -> no ack; next req issues normally; req held through ack -> second transaction.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared types and constants for the CPU-side MMIO decoder.
package mmio_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RAM_WAIT = 2'd1,
    DONE     = 2'd2
  } mmio_state_t;

  localparam logic [1:0] OP_WRITE  = 2'b00;
  localparam logic [1:0] OP_SET    = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  localparam int unsigned IDX_W = 4;
  localparam int unsigned CNT_W = 3;

endpackage

// File: rtl/mmio_decoder_if.sv
// CPU request/response bus between a requester (master) and the decoder (slave).
interface mmio_decoder_if #(
  parameter int unsigned AW = 12,
  parameter int unsigned DW = 8
) ();

  logic          cpu_req;
  logic          cpu_rw;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;
  logic          cpu_err;

  modport master (
    output cpu_req, cpu_rw, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack, cpu_err
  );

  modport slave (
    input  cpu_req, cpu_rw, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack, cpu_err
  );

endinterface

// File: rtl/mmio_port_reg.sv
// One output port register with write/set/clear/toggle update and an update strobe.
module mmio_port_reg
  import mmio_pkg::*;
#(
  parameter int unsigned   DW       = 8,
  parameter logic [DW-1:0] PORT_RST = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [1:0]    op,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] q,
  output logic          stb
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q   <= PORT_RST;
      stb <= 1'b0;
    end else begin
      stb <= we;
      if (we) begin
        case (op)
          OP_WRITE: q <= wdata;
          OP_SET:   q <= q | wdata;
          OP_CLEAR: q <= q & ~wdata;
          default:  q <= q ^ wdata;
        endcase
      end
    end
  end

endmodule

// File: rtl/mmio_decoder.sv
// CPU address decoder: RAM window with latency sequencing, I/O window of port registers.
module mmio_decoder
  import mmio_pkg::*;
#(
  parameter int unsigned   AW        = 12,
  parameter int unsigned   DW        = 8,
  parameter int unsigned   NUM_PORTS = 4,
  parameter int unsigned   RAM_LAT   = 1,
  parameter logic [DW-1:0] PORT_RST  = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  mmio_decoder_if.slave           cpu,
  output logic                    ram_cs,
  output logic                    ram_rw,
  output logic [AW-2:0]           ram_addr,
  output logic [DW-1:0]           ram_wdata,
  input  logic [DW-1:0]           ram_rdata,
  output logic [NUM_PORTS*DW-1:0] port_out,
  output logic [NUM_PORTS-1:0]    port_stb
);

  mmio_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic             ram_rd;

  logic [IDX_W-1:0] idx;
  logic [1:0]       op;
  logic             idx_ok;
  logic             io_sel;
  logic             start;
  logic             io_wr;
  logic [DW-1:0]    rd_mux;
  logic [DW-1:0]    port_q [NUM_PORTS];

  assign idx    = cpu.cpu_addr[5:2];
  assign op     = cpu.cpu_addr[1:0];
  assign idx_ok = 5'(idx) < 5'(NUM_PORTS);
  assign io_sel = cpu.cpu_addr[AW-1];
  assign start  = (state == IDLE) && cpu.cpu_req;
  assign io_wr  = start && io_sel && !cpu.cpu_rw && idx_ok;

  // RAM select is issued straight from the IDLE request; suppressed while in reset
  assign ram_cs    = start && !io_sel && !reset;
  assign ram_rw    = cpu.cpu_rw;
  assign ram_addr  = cpu.cpu_addr[AW-2:0];
  assign ram_wdata = cpu.cpu_wdata;

  for (genvar i = 0; i < int'(NUM_PORTS); i++) begin : g_port
    mmio_port_reg #(
      .DW       (DW),
      .PORT_RST (PORT_RST)
    ) u_port (
      .clk   (clk),
      .reset (reset),
      .we    (io_wr && (idx == IDX_W'(i))),
      .op    (op),
      .wdata (cpu.cpu_wdata),
      .q     (port_q[i]),
      .stb   (port_stb[i])
    );
    assign port_out[i*DW +: DW] = port_q[i];
  end

  // Pre-update port value; unmapped indices read as zero
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      if (idx == IDX_W'(i)) rd_mux = port_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      ram_rd        <= 1'b0;
      cpu.cpu_ack   <= 1'b0;
      cpu.cpu_err   <= 1'b0;
      cpu.cpu_rdata <= '0;
    end else begin
      cpu.cpu_ack <= 1'b0;
      cpu.cpu_err <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu.cpu_req) begin
            if (io_sel) begin
              cpu.cpu_rdata <= rd_mux;
              cpu.cpu_err   <= !idx_ok;
              cpu.cpu_ack   <= 1'b1;
              state         <= DONE;
            end else begin
              cnt    <= CNT_W'(RAM_LAT - 1);
              ram_rd <= cpu.cpu_rw;
              state  <= RAM_WAIT;
            end
          end
        end
        RAM_WAIT: begin
          if (cnt == '0) begin
            cpu.cpu_rdata <= ram_rd ? ram_rdata : '0;
            cpu.cpu_ack   <= 1'b1;
            state         <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_decoder.sv
// Scoreboard bench for mmio_decoder (NUM_PORTS=4, RAM_LAT=3) with a behavioural RAM.
module tb_mmio_decoder;

  localparam int unsigned AW  = 12;
  localparam int unsigned DW  = 8;
  localparam int unsigned NP  = 4;
  localparam int unsigned LAT = 3;

  typedef struct {
    int         exp_cyc;
    logic [7:0] rdata;
    logic       chk_rd;
    logic       err;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            ram_cs, ram_rw;
  logic [AW-2:0]   ram_addr;
  logic [DW-1:0]   ram_wdata, ram_rdata;
  logic [NP*DW-1:0] port_out;
  logic [NP-1:0]   port_stb;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   cs_cnt = 0;
  logic [AW-2:0] cs_addr = '0;
  int   stb_cnt [NP];
  exp_t sb [$];

  logic [7:0] mem  [0:2047];
  logic [7:0] pipe [LAT];

  mmio_decoder_if #(.AW(AW), .DW(DW)) bus ();

  mmio_decoder #(
    .AW(AW), .DW(DW), .NUM_PORTS(NP), .RAM_LAT(LAT), .PORT_RST(8'h00)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu       (bus),
    .ram_cs    (ram_cs),
    .ram_rw    (ram_rw),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .port_out  (port_out),
    .port_stb  (port_stb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: read data appears LAT cycles after the select, filler otherwise
  always @(posedge clk) begin
    if (ram_cs && !ram_rw) mem[ram_addr] <= ram_wdata;
    pipe[0] <= (ram_cs && ram_rw) ? mem[ram_addr] : 8'hEE;
    for (int i = 1; i < int'(LAT); i++) pipe[i] <= pipe[i-1];
  end
  assign ram_rdata = pipe[LAT-1];

  initial for (int i = 0; i < int'(NP); i++) stb_cnt[i] = 0;

  always @(negedge clk) begin
    if (ram_cs) begin
      cs_cnt++;
      cs_addr = ram_addr;
    end
    for (int i = 0; i < int'(NP); i++) stb_cnt[i] += int'(port_stb[i]);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] port(input int i);
    return port_out[i*8 +: 8];
  endfunction

  // Monitor: every ack is matched against the oldest expectation
  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.cpu_ack === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got ack at cycle %0d expected none", cyc);
      end else begin
        e = sb.pop_front();
        chk("ack_cycle", cyc, e.exp_cyc);
        chk("err", 32'(bus.cpu_err), 32'(e.err));
        if (e.chk_rd) chk("rdata", 32'(bus.cpu_rdata), 32'(e.rdata));
      end
    end
  end

  task automatic push_exp(input int lat, input logic [7:0] rd, input logic chk_rd, input logic err);
    exp_t e;
    e.exp_cyc = cyc + lat;
    e.rdata   = rd;
    e.chk_rd  = chk_rd;
    e.err     = err;
    sb.push_back(e);
  endtask

  // Issue one transaction in an IDLE cycle, drop req in the ack cycle, return in the next IDLE cycle
  task automatic xact(input logic rw, input logic [11:0] addr, input logic [7:0] wd,
                      input logic [7:0] erd, input logic chk_rd, input logic err, input int lat);
    bit got;
    bus.cpu_req   = 1'b1;
    bus.cpu_rw    = rw;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wd;
    push_exp(lat, erd, chk_rd, err);
    got = 1'b0;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clk);
      if (bus.cpu_ack === 1'b1) got = 1'b1;
    end
    bus.cpu_req = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: no ack for addr 0x%0h within 30 cycles", addr);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin : stim
    int         c0;
    int         s0 [NP];
    logic [31:0] snap;
    int         acks;

    reset         = 1'b1;
    bus.cpu_req   = 1'b1;
    bus.cpu_rw    = 1'b1;
    bus.cpu_addr  = 12'h010;
    bus.cpu_wdata = 8'h00;

    // Reset held with a pending RAM request
    repeat (3) begin
      @(negedge clk);
      chk("rst_ack", 32'(bus.cpu_ack), 0);
      chk("rst_ram_cs", 32'(ram_cs), 0);
      chk("rst_ports", port_out, 0);
      chk("rst_rdata", 32'(bus.cpu_rdata), 0);
      chk("rst_stb", 32'(port_stb), 0);
    end
    bus.cpu_req = 1'b0;
    reset       = 1'b0;
    @(negedge clk);
    chk("rst_cs_count", cs_cnt, 0);

    // Port write and read-back
    xact(1'b0, 12'h804, 8'hA5, 8'h00, 1'b0, 1'b0, 1);
    chk("p1_write", 32'(port(1)), 32'h A5);
    xact(1'b1, 12'h804, 8'h00, 8'hA5, 1'b1, 1'b0, 1);
    chk("stb_after_wr_rd", {stb_cnt[3][7:0], stb_cnt[2][7:0], stb_cnt[1][7:0], stb_cnt[0][7:0]},
        32'h0000_0100);

    // Set / clear / toggle
    xact(1'b0, 12'h805, 8'h0F, 8'h00, 1'b0, 1'b0, 1);
    chk("p1_set", 32'(port(1)), 32'hAF);
    xact(1'b0, 12'h806, 8'hA0, 8'h00, 1'b0, 1'b0, 1);
    chk("p1_clear", 32'(port(1)), 32'h0F);
    xact(1'b0, 12'h807, 8'hFF, 8'h00, 1'b0, 1'b0, 1);
    chk("p1_toggle", 32'(port(1)), 32'hF0);
    xact(1'b1, 12'h807, 8'h00, 8'hF0, 1'b1, 1'b0, 1);
    xact(1'b1, 12'h844, 8'h00, 8'hF0, 1'b1, 1'b0, 1);
    xact(1'b0, 12'h80B, 8'h00, 8'h00, 1'b0, 1'b0, 1);
    chk("p2_toggle0_stb", stb_cnt[2], 1);
    chk("p2_toggle0_val", 32'(port(2)), 0);
    chk("p1_stb_total", stb_cnt[1], 4);

    // RAM window with latency 3
    c0 = cs_cnt;
    xact(1'b0, 12'h010, 8'h3C, 8'h00, 1'b1, 1'b0, 4);
    chk("ram_wr_cs", cs_cnt - c0, 1);
    chk("ram_wr_addr", 32'(cs_addr), 32'h010);
    xact(1'b1, 12'h010, 8'h00, 8'h3C, 1'b1, 1'b0, 4);
    chk("ram_rd_cs", cs_cnt - c0, 2);
    xact(1'b0, 12'h7FF, 8'h5A, 8'h00, 1'b1, 1'b0, 4);
    xact(1'b1, 12'h7FF, 8'h00, 8'h5A, 1'b1, 1'b0, 4);
    chk("ram_top_addr", 32'(cs_addr), 32'h7FF);

    // Highest mapped index, then unmapped index
    xact(1'b0, 12'h80C, 8'h33, 8'h00, 1'b0, 1'b0, 1);
    chk("p3_write", 32'(port(3)), 32'h33);
    snap = port_out;
    for (int i = 0; i < int'(NP); i++) s0[i] = stb_cnt[i];
    xact(1'b0, 12'h814, 8'hFF, 8'h00, 1'b0, 1'b1, 1);
    chk("unmapped_no_change", port_out, snap);
    chk("unmapped_no_stb", stb_cnt[0] + stb_cnt[1] + stb_cnt[2] + stb_cnt[3],
        s0[0] + s0[1] + s0[2] + s0[3]);
    xact(1'b1, 12'h814, 8'h00, 8'h00, 1'b1, 1'b1, 1);

    // Reset while a RAM read is waiting: no ack, ports cleared
    c0 = cs_cnt;
    bus.cpu_req  = 1'b1;
    bus.cpu_rw   = 1'b1;
    bus.cpu_addr = 12'h010;
    @(negedge clk);
    reset       = 1'b1;
    bus.cpu_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("abort_no_ack", 32'(bus.cpu_ack), 0);
    end
    chk("abort_cs_once", cs_cnt - c0, 1);
    chk("abort_ports_rst", port_out, 0);
    xact(1'b1, 12'h010, 8'h00, 8'h3C, 1'b1, 1'b0, 4);

    // Request held through the ack starts a second transaction
    s0[0] = stb_cnt[0];
    bus.cpu_req   = 1'b1;
    bus.cpu_rw    = 1'b0;
    bus.cpu_addr  = 12'h803;
    bus.cpu_wdata = 8'h55;
    push_exp(1, 8'h00, 1'b0, 1'b0);
    push_exp(3, 8'h00, 1'b0, 1'b0);
    acks = 0;
    for (int k = 0; k < 30 && acks < 2; k++) begin
      @(negedge clk);
      if (bus.cpu_ack === 1'b1) acks++;
    end
    bus.cpu_req = 1'b0;
    chk("held_two_acks", acks, 2);
    @(negedge clk);
    chk("held_stb", stb_cnt[0] - s0[0], 2);
    chk("held_val", 32'(port(0)), 0);

    repeat (8) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
